// File: rtl/ahbl_rx_fifo_dreq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ahbl_rx_fifo_dreq                                                        |
// | Push-only receive FIFO with AHB-Lite register window and level DREQ.     |
// | Optional: AHBL_RX_FIFO_OVF_IRQ_EN adds registered IRQ = OVF | UNF.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ahbl_rx_fifo_dreq #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  input  logic        IN_VALID,
  input  logic [31:0] IN_DATA,
`ifdef AHBL_RX_FIFO_OVF_IRQ_EN
  output logic        IRQ,
`endif
  output logic        DREQ
);

  localparam int LW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, rptr_eff;
  logic [LW-1:0] lvl_q, lvl_d, lvl_eff;
  logic          en_q, en_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [7:0]    thr_q, thr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          dph_vld_q, dph_wr_q, dph_pop_q, dph_pop_d;
  logic [7:0]    dph_addr_q;
  logic [8:0]    thr_eff;

  logic addr_ph, wr_dph, data_rd, cmd_wr, ctrl_wr;
  logic flush, clr_ovf, clr_unf, full, push_req, push, pop, ovf_set, unf_set;

  assign addr_ph  = HSEL & HREADY & HTRANS[1];
  assign wr_dph   = dph_vld_q & dph_wr_q;
  assign data_rd  = dph_vld_q & ~dph_wr_q & (dph_addr_q == 8'h00);
  assign cmd_wr   = wr_dph & (dph_addr_q == 8'h0C);
  assign ctrl_wr  = wr_dph & (dph_addr_q == 8'h08);
  assign flush    = cmd_wr & HWDATA[0];
  assign clr_ovf  = cmd_wr & HWDATA[1];
  assign clr_unf  = cmd_wr & HWDATA[2];
  assign full     = (lvl_q == LW'(DEPTH));
  assign push_req = IN_VALID & en_q & ~flush;
  assign push     = push_req & ~full;
  assign ovf_set  = push_req & full;
  assign pop      = data_rd & dph_pop_q & (lvl_q != '0);
  assign unf_set  = data_rd & ~dph_pop_q;

  // A read address phase overlaps the previous access's data phase, so it
  // must see the FIFO as it will be after that pending pop or flush commits.
  assign lvl_eff  = flush ? '0 : (lvl_q - LW'(pop));
  assign rptr_eff = rptr_q + AW'(pop);
  assign dph_pop_d = addr_ph & ~HWRITE & (HADDR[7:0] == 8'h00) & (lvl_eff != '0);

  always_comb begin
    wptr_d = flush ? '0 : wptr_q + AW'(push);
    rptr_d = flush ? '0 : rptr_q + AW'(pop);
    lvl_d  = flush ? '0 : lvl_q + LW'(push) - LW'(pop);
    ovf_d  = ovf_set | (ovf_q & ~clr_ovf);
    unf_d  = unf_set | (unf_q & ~clr_unf);
    en_d   = ctrl_wr ? HWDATA[0]    : en_q;
    thr_d  = ctrl_wr ? HWDATA[15:8] : thr_q;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (addr_ph) begin
      if (HWRITE) begin
        rdata_d = 32'h0;
      end else begin
        case (HADDR[7:0])
          8'h00:   rdata_d = (lvl_eff != '0) ? mem_q[rptr_eff] : 32'h0;
          8'h04:   rdata_d = {12'h0, unf_q, ovf_q, full, (lvl_q == '0), 8'h00, 8'(lvl_q)};
          8'h08:   rdata_d = {16'h0, thr_q, 7'h00, en_q};
          8'h0C:   rdata_d = 32'h0;
          default: rdata_d = 32'hDEADBEEF;
        endcase
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      lvl_q      <= '0;
      en_q       <= 1'b0;
      thr_q      <= 8'h00;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rdata_q    <= 32'h0;
      dph_vld_q  <= 1'b0;
      dph_wr_q   <= 1'b0;
      dph_pop_q  <= 1'b0;
      dph_addr_q <= 8'h00;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      lvl_q      <= lvl_d;
      en_q       <= en_d;
      thr_q      <= thr_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rdata_q    <= rdata_d;
      dph_vld_q  <= addr_ph;
      dph_wr_q   <= HWRITE;
      dph_pop_q  <= dph_pop_d;
      dph_addr_q <= HADDR[7:0];
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem_q[wptr_q] <= IN_DATA;
    end
  end

`ifdef AHBL_RX_FIFO_OVF_IRQ_EN
  logic irq_q;
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= ovf_q | unf_q;
    end
  end
  assign IRQ = irq_q;
`endif

  // THR of 0 behaves as 1; values beyond DEPTH saturate so DREQ stays reachable.
  assign thr_eff = (thr_q == 8'h00) ? 9'd1 :
                   ({1'b0, thr_q} > 9'(DEPTH)) ? 9'(DEPTH) : {1'b0, thr_q};

  assign DREQ      = en_q & (9'(lvl_q) >= thr_eff);
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign HRDATA    = rdata_q;

  logic unused_ok;
  assign unused_ok = ^{HADDR[31:8], HSIZE, HTRANS[0], HWDATA[31:16], HWDATA[7:3]};

endmodule
`default_nettype wire

// File: tb/tb_ahbl_rx_fifo_dreq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ahbl_rx_fifo_dreq                                                     |
// | Scoreboard bench: reads queue expected HRDATA, a monitor compares them.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ahbl_rx_fifo_dreq;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY, IN_VALID;
  logic [31:0] HADDR, HWDATA, IN_DATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADYOUT, HRESP, DREQ;
`ifdef AHBL_RX_FIFO_OVF_IRQ_EN
  logic        IRQ;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        tb_rd_dph;

  ahbl_rx_fifo_dreq #(.DEPTH(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
`ifdef AHBL_RX_FIFO_OVF_IRQ_EN
    .IRQ(IRQ),
`endif
    .DREQ(DREQ)
  );

  always #5 HCLK = ~HCLK;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  // Monitor: a read data phase follows every read address phase on the bus.
  always @(posedge HCLK) begin
    if (HRESET) tb_rd_dph <= 1'b0;
    else        tb_rd_dph <= HSEL && HREADY && HTRANS[1] && !HWRITE;
  end

  always @(negedge HCLK) begin
    if (tb_rd_dph) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual=%h required=none", HRDATA);
      end else begin
        chk(name_q.pop_front(), HRDATA, exp_q.pop_front());
      end
    end
  end

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
  endtask

  task automatic ahb_wr(input logic [31:0] a, input logic [31:0] d,
                        input bit push_dp = 1'b0, input logic [31:0] pd = 32'h0);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = d; IN_VALID = push_dp; IN_DATA = pd;
    @(posedge HCLK); #1;
    IN_VALID = 1'b0; HWDATA = 32'h0;
  endtask

  task automatic ahb_rd(input logic [31:0] a, input logic [31:0] e, input string nm,
                        input bit push_dp = 1'b0, input logic [31:0] pd = 32'h0);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    exp_q.push_back(e); name_q.push_back(nm);
    @(posedge HCLK); #1;
    bus_idle();
    IN_VALID = push_dp; IN_DATA = pd;
    @(posedge HCLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic rd_burst(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0;
      exp_q.push_back(base + 32'(i)); name_q.push_back($sformatf("burst_rd%0d", i));
      @(posedge HCLK); #1;
    end
    bus_idle();
    @(posedge HCLK); #1;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      IN_VALID = 1'b1; IN_DATA = base + 32'(i);
      @(posedge HCLK); #1;
    end
    IN_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1; HREADY = 1'b1; HSIZE = 3'b010; HWDATA = 32'h0;
    IN_VALID = 1'b0; IN_DATA = 32'h0;
    bus_idle();
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;

    // Reset state
    chk("reset_dreq", {31'h0, DREQ}, 32'h0);
    chk("reset_hrdata", HRDATA, 32'h0);
    ahb_rd(32'h04, 32'h0001_0000, "reset_status");
    ahb_rd(32'h08, 32'h0, "reset_ctrl");
    ahb_rd(32'h0C, 32'h0, "cmd_reads_zero");
    ahb_rd(32'h10, 32'hDEADBEEF, "unmapped_rd");

    // Threshold 4
    ahb_wr(32'h08, 32'h0000_0401);
    ahb_rd(32'h08, 32'h0000_0401, "ctrl_rb");
    push_words(32'hA0, 3);
    chk("dreq_lvl3", {31'h0, DREQ}, 32'h0);
    push_words(32'hA3, 1);
    chk("dreq_lvl4", {31'h0, DREQ}, 32'h1);
    ahb_rd(32'h00, 32'hA0, "thr_rd0");
    chk("dreq_after_pop", {31'h0, DREQ}, 32'h0);
    ahb_rd(32'h00, 32'hA1, "thr_rd1");
    ahb_rd(32'h00, 32'hA2, "thr_rd2");
    ahb_rd(32'h00, 32'hA3, "thr_rd3");
    ahb_rd(32'h04, 32'h0001_0000, "thr_status_empty");

    // Overflow and underflow
    push_words(32'hB0, 17);
    ahb_rd(32'h04, 32'h0006_0010, "ovf_status_full");
    chk("dreq_full", {31'h0, DREQ}, 32'h1);
    rd_burst(32'hB0, 16);
    ahb_rd(32'h00, 32'h0, "underflow_rd");
    ahb_rd(32'h04, 32'h000D_0000, "unf_status");
    ahb_wr(32'h0C, 32'h6);
    ahb_rd(32'h04, 32'h0001_0000, "flags_cleared");

    // Flush beats push
    push_words(32'hC0, 5);
    ahb_rd(32'h04, 32'h0000_0005, "lvl5_status");
    ahb_wr(32'h0C, 32'h1, 1'b1, 32'hEE);
    ahb_rd(32'h04, 32'h0001_0000, "flush_status");
    push_words(32'hD0, 1);
    ahb_rd(32'h00, 32'hD0, "post_flush_rd");

    // Disabled pushes, THR=0, EN clear keeps data
    ahb_wr(32'h08, 32'h0);
    push_words(32'h77, 4);
    ahb_rd(32'h04, 32'h0001_0000, "en0_status");
    chk("en0_dreq", {31'h0, DREQ}, 32'h0);
    ahb_wr(32'h08, 32'h1);
    push_words(32'hE0, 1);
    chk("thr0_dreq", {31'h0, DREQ}, 32'h1);
    ahb_rd(32'h00, 32'hE0, "thr0_rd");
    chk("thr0_dreq_drop", {31'h0, DREQ}, 32'h0);
    push_words(32'hE1, 1);
    ahb_wr(32'h08, 32'h0);
    chk("en_clr_dreq", {31'h0, DREQ}, 32'h0);
    ahb_rd(32'h00, 32'hE1, "en_clr_rd");

    // Full FIFO: pop concurrent with dropped push
    ahb_wr(32'h08, 32'h0401);
    push_words(32'hF0, 16);
    ahb_rd(32'h04, 32'h0002_0010, "full_status");
    ahb_rd(32'h00, 32'hF0, "full_pop_rd", 1'b1, 32'h55);
    ahb_rd(32'h04, 32'h0004_000F, "full_pop_status");
    chk("full_pop_dreq", {31'h0, DREQ}, 32'h1);
`ifdef AHBL_RX_FIFO_OVF_IRQ_EN
    chk("irq_set", {31'h0, IRQ}, 32'h1);
`endif
    ahb_wr(32'h0C, 32'h2);
`ifdef AHBL_RX_FIFO_OVF_IRQ_EN
    chk("irq_hold", {31'h0, IRQ}, 32'h1);
    @(posedge HCLK); #1;
    chk("irq_clr", {31'h0, IRQ}, 32'h0);
`endif
    ahb_rd(32'h04, 32'h0000_000F, "ovf_clr_status");

    // Set and clear of OVF in the same cycle leaves it set
    push_words(32'h99, 1);
    ahb_wr(32'h0C, 32'h2, 1'b1, 32'h66);
    ahb_rd(32'h04, 32'h0006_0010, "sticky_priority");
    ahb_wr(32'h0C, 32'h2);
    ahb_rd(32'h04, 32'h0002_0010, "sticky_cleared");

    // THR above DEPTH saturates
    ahb_wr(32'h08, 32'h0000_FF01);
    ahb_rd(32'h08, 32'h0000_FF01, "ctrl_ff");
    chk("thr_sat_dreq", {31'h0, DREQ}, 32'h1);
    ahb_wr(32'h0C, 32'h1);
    chk("flush_dreq", {31'h0, DREQ}, 32'h0);
    ahb_rd(32'h04, 32'h0001_0000, "final_status");

    repeat (2) @(posedge HCLK);
    #1;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
